// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath: grid geometry,
// the food FSM states, the food colour and the LFSR step function.
package snake_pkg;

    localparam int GRID_BITS = 4;
    localparam int GRID_SIZE = 1 << GRID_BITS;

    typedef logic [GRID_BITS-1:0] coord_t;

    localparam logic [2:0] FOOD_COLOUR = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAND_Q,
        S_RAND_W,
        S_SCAN_Q,
        S_SCAN_W,
        S_DONE
    } food_state_t;

    // Fibonacci step for x^8+x^6+x^5+x^4+1; zero is never reached from a nonzero seed.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit maximal-length LFSR, shared by the food placer
// and any other game block that needs cheap randomness.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] q
);
    import snake_pkg::*;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/food_gen.sv
// Picks a free grid cell for new food: random LFSR tries first,
// then a row-major scan so a nearly full board still terminates.
module food_gen #(
    parameter int         GRID_BITS = 4,
    parameter int         MAX_TRIES = 16,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                 CLOCK_50,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 waitrequest,
    output logic                 query_valid,
    output logic [GRID_BITS-1:0] query_x,
    output logic [GRID_BITS-1:0] query_y,
    input  logic                 query_hit,
    output logic                 food_valid,
    output logic [GRID_BITS-1:0] food_x,
    output logic [GRID_BITS-1:0] food_y,
    output logic                 no_space
);
    import snake_pkg::*;

    localparam int TW = $clog2(MAX_TRIES) + 1;
    localparam logic [GRID_BITS-1:0] LAST = '1;

    food_state_t state, state_d;

    logic [7:0]           lfsr;
    logic [TW-1:0]        tries, tries_d;
    logic [GRID_BITS-1:0] cand_x, cand_x_d;
    logic [GRID_BITS-1:0] cand_y, cand_y_d;
    logic [GRID_BITS-1:0] scan_x, scan_x_d;
    logic [GRID_BITS-1:0] scan_y, scan_y_d;
    logic [GRID_BITS-1:0] fx_d, fy_d;
    logic                 full, full_d;

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .q     (lfsr)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            tries  <= '0;
            cand_x <= '0;
            cand_y <= '0;
            scan_x <= '0;
            scan_y <= '0;
            food_x <= '0;
            food_y <= '0;
            full   <= 1'b0;
        end else begin
            state  <= state_d;
            tries  <= tries_d;
            cand_x <= cand_x_d;
            cand_y <= cand_y_d;
            scan_x <= scan_x_d;
            scan_y <= scan_y_d;
            food_x <= fx_d;
            food_y <= fy_d;
            full   <= full_d;
        end
    end

    always_comb begin
        state_d  = state;
        tries_d  = tries;
        cand_x_d = cand_x;
        cand_y_d = cand_y;
        scan_x_d = scan_x;
        scan_y_d = scan_y;
        fx_d     = food_x;
        fy_d     = food_y;
        full_d   = full;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    cand_x_d = lfsr[4 +: GRID_BITS];
                    cand_y_d = lfsr[0 +: GRID_BITS];
                    tries_d  = '0;
                    full_d   = 1'b0;
                    state_d  = S_RAND_Q;
                end
            end
            S_RAND_Q: state_d = S_RAND_W;
            S_RAND_W: begin
                if (!query_hit) begin
                    fx_d    = cand_x;
                    fy_d    = cand_y;
                    state_d = S_DONE;
                end else if (tries < TW'(MAX_TRIES - 1)) begin
                    tries_d  = tries + 1'b1;
                    cand_x_d = lfsr[4 +: GRID_BITS];
                    cand_y_d = lfsr[0 +: GRID_BITS];
                    state_d  = S_RAND_Q;
                end else begin
                    scan_x_d = '0;
                    scan_y_d = '0;
                    state_d  = S_SCAN_Q;
                end
            end
            S_SCAN_Q: state_d = S_SCAN_W;
            S_SCAN_W: begin
                if (!query_hit) begin
                    fx_d    = scan_x;
                    fy_d    = scan_y;
                    state_d = S_DONE;
                end else if (scan_x == LAST && scan_y == LAST) begin
                    full_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    scan_x_d = scan_x + 1'b1;
                    if (scan_x == LAST) begin
                        scan_y_d = scan_y + 1'b1;
                    end
                    state_d = S_SCAN_Q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are pure functions of registered state, so reset clears them in one edge.
    logic in_scan;
    assign in_scan     = (state == S_SCAN_Q) || (state == S_SCAN_W);
    assign waitrequest = (state != S_IDLE) && (state != S_DONE);
    assign query_valid = (state == S_RAND_Q) || (state == S_SCAN_Q);
    assign query_x     = in_scan ? scan_x : cand_x;
    assign query_y     = in_scan ? scan_y : cand_y;
    assign food_valid  = (state == S_DONE) && !full;
    assign no_space    = (state == S_DONE) && full;

endmodule

// File: tb/tb_food_gen.sv
// Randomized scoreboard bench for food_gen: a cell-level model predicts
// every query and every result, a negedge monitor checks them.
module tb_food_gen;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       query_hit = 1'b0;
    logic       waitrequest, query_valid, food_valid, no_space;
    logic [3:0] query_x, query_y, food_x, food_y;

    always #5 CLOCK_50 = ~CLOCK_50;

    food_gen #(
        .GRID_BITS (4),
        .MAX_TRIES (16),
        .LFSR_SEED (8'hA5)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .rst_n       (rst_n),
        .start       (start),
        .waitrequest (waitrequest),
        .query_valid (query_valid),
        .query_x     (query_x),
        .query_y     (query_y),
        .query_hit   (query_hit),
        .food_valid  (food_valid),
        .food_x      (food_x),
        .food_y      (food_y),
        .no_space    (no_space)
    );

    function automatic logic [7:0] lstep(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    int         cyc = 0;
    logic [7:0] mlfsr = 8'hA5;
    logic       occ [16][16];

    always @(posedge CLOCK_50) cyc <= cyc + 1;
    always @(posedge CLOCK_50) mlfsr <= !rst_n ? 8'hA5 : lstep(mlfsr);

    // Registered responder; drives junk whenever no query is outstanding.
    always @(posedge CLOCK_50)
        query_hit <= query_valid ? occ[query_y][query_x] : 1'($urandom);

    typedef struct {
        int         c;
        logic [3:0] x;
        logic [3:0] y;
    } q_t;

    typedef struct {
        int         c;
        logic       full;
        logic [3:0] x;
        logic [3:0] y;
    } r_t;

    q_t qexp[$];
    r_t rexp[$];

    int         compared = 0;
    int         mismatched = 0;
    int         results_seen = 0;
    int         t_acc = 0;
    int         done_cyc = 0;
    bit         tx_on = 0;
    logic [3:0] mfx = 4'd0;
    logic [3:0] mfy = 4'd0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge CLOCK_50) begin
        q_t q;
        r_t r;
        if (tx_on && cyc >= t_acc && cyc <= done_cyc)
            chk("waitrequest", 32'(waitrequest), 32'(cyc < done_cyc));
        if (query_valid) begin
            if (qexp.size() == 0) begin
                chk("unexpected_query", 1, 0);
            end else begin
                q = qexp.pop_front();
                chk("query_cycle", cyc, q.c);
                chk("query_x", 32'(query_x), 32'(q.x));
                chk("query_y", 32'(query_y), 32'(q.y));
            end
        end
        if (food_valid || no_space) begin
            if (rexp.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                r = rexp.pop_front();
                chk("result_cycle", cyc, r.c);
                chk("no_space", 32'(no_space), 32'(r.full));
                chk("food_valid", 32'(food_valid), 32'(!r.full));
                chk("food_x", 32'(food_x), 32'(r.x));
                chk("food_y", 32'(food_y), 32'(r.y));
            end
            results_seen++;
        end
    end

    task automatic fill(input int pct);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                occ[y][x] = ($urandom_range(99) < pct);
    endtask

    // Predict the whole transaction from the occupancy map and LFSR stream.
    task automatic launch();
        logic [7:0] v;
        logic [3:0] x, y;
        int         t;
        bit         found;
        q_t         q;
        r_t         r;
        v = mlfsr;
        t = cyc + 1;
        found = 0;
        for (int k = 0; k < 16; k++) begin
            if (!found) begin
                x = v[7:4];
                y = v[3:0];
                q.c = t + 2 * k; q.x = x; q.y = y;
                qexp.push_back(q);
                if (!occ[y][x]) begin
                    r.c = t + 2 * k + 2; r.full = 0; r.x = x; r.y = y;
                    rexp.push_back(r);
                    mfx = x; mfy = y; done_cyc = r.c; found = 1;
                end
                v = lstep(lstep(v));
            end
        end
        for (int n = 0; n < 256; n++) begin
            if (!found) begin
                x = 4'(n % 16);
                y = 4'(n / 16);
                q.c = t + 32 + 2 * n; q.x = x; q.y = y;
                qexp.push_back(q);
                if (!occ[y][x]) begin
                    r.c = t + 34 + 2 * n; r.full = 0; r.x = x; r.y = y;
                    rexp.push_back(r);
                    mfx = x; mfy = y; done_cyc = r.c; found = 1;
                end
            end
        end
        if (!found) begin
            r.c = t + 544; r.full = 1; r.x = mfx; r.y = mfy;
            rexp.push_back(r);
            done_cyc = r.c;
        end
        t_acc = t;
        tx_on = 1;
        start = 1'b1;
    endtask

    task automatic wait_done();
        int target;
        int b;
        target = results_seen + 1;
        b = 0;
        while (results_seen < target && b < 800) begin
            @(posedge CLOCK_50);
            #1;
            b++;
            start = (waitrequest || food_valid || no_space) ? 1'($urandom) : 1'b0;
        end
        start = 1'b0;
        tx_on = 0;
        if (results_seen < target) chk("result_timeout", 0, 1);
    endtask

    task automatic run(input int pct);
        fill(pct);
        launch();
        wait_done();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_waitrequest"}, 32'(waitrequest), 0);
        chk({tag, "_query_valid"}, 32'(query_valid), 0);
        chk({tag, "_food_valid"}, 32'(food_valid), 0);
        chk({tag, "_no_space"}, 32'(no_space), 0);
        chk({tag, "_food_x"}, 32'(food_x), 0);
        chk({tag, "_food_y"}, 32'(food_y), 0);
        chk({tag, "_query_x"}, 32'(query_x), 0);
        chk({tag, "_lfsr"}, 32'(dut.u_lfsr.q), 32'h00A5);
    endtask

    initial begin
        logic [7:0] v;
        fill(0);
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_idle("reset");
        rst_n = 1'b1;

        repeat (4) run(0);

        repeat (3) begin
            fill(0);
            v = mlfsr;
            for (int k = 0; k < 3; k++) begin
                occ[v[3:0]][v[7:4]] = 1'b1;
                v = lstep(lstep(v));
            end
            launch();
            wait_done();
        end

        run(100);
        occ[2][5] = 1'b0;
        launch();
        wait_done();

        run(0);
        run(100);

        for (int i = 0; i < 6; i++) run(int'($urandom_range(99, 50)));

        fill(100);
        launch();
        repeat (100) begin
            @(posedge CLOCK_50);
            #1;
            start = 1'($urandom);
        end
        rst_n = 1'b0;
        start = 1'b0;
        @(posedge CLOCK_50);
        #1;
        rst_n = 1'b1;
        qexp.delete();
        rexp.delete();
        tx_on = 0;
        mfx = 4'd0;
        mfy = 4'd0;
        check_idle("midreset");
        run(0);

        repeat (3) @(posedge CLOCK_50);
        chk("leftover_queries", qexp.size(), 0);
        chk("leftover_results", rexp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/food_gen.md
# food_gen

Places a new food cell on the 16x16 snake game grid. On request it draws pseudo-random candidate cells from a free-running LFSR and checks each one against the snake body through an occupancy query port. If every random try lands on the snake, it falls back to a deterministic row-major scan. It sits directly upstream of game_path: game_path requests food, answers occupancy queries from its body store, and consumes the result before drawing it through game_plot.

## Interface
Parameters:
- GRID_BITS, 4, bits per grid coordinate (grid is 2^GRID_BITS square).
- MAX_TRIES, 16, random candidates tried before falling back to the scan.
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- Reset rst_n, synchronous, active-low; clock CLOCK_50.
- CLOCK_50 input 1: system clock.
- rst_n input 1: synchronous active-low reset.
- start input 1: request a new food cell.
- waitrequest output 1: 0 = idle and accepting; 1 = busy.
- query_valid output 1: occupancy query strobe.
- query_x, query_y output GRID_BITS each: cell being queried.
- query_hit input 1: 1 = queried cell is occupied by the snake.
- food_valid output 1: one-cycle pulse; food_x/food_y are valid.
- food_x, food_y output GRID_BITS each: last placed food cell.
- no_space output 1: one-cycle pulse when every cell is occupied.

## Operation
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Advances every cycle, in every state, so player timing adds entropy.
  - Never 0; the candidate is (lfsr[7:4], lfsr[3:0]).
  - Resets to LFSR_SEED.
- States:
  - IDLE
  - RAND_Q: query_valid=1 with the latched candidate.
  - RAND_W: sample query_hit.
  - SCAN_Q
  - SCAN_W
  - DONE
- IDLE: when start=1, latch the current LFSR candidate, clear the try counter, and go to RAND_Q. waitrequest=0.
- RAND_W:
  - hit=0: load food_x/y from the candidate and go to DONE.
  - hit=1 and tries<MAX_TRIES-1: increment tries, latch a new candidate, go to RAND_Q.
  - Otherwise: set the scan cell to (0,0) and go to SCAN_Q.
- SCAN_Q/SCAN_W: same query/sample pair over the scan cell.
  - x increments first; y increments when x wraps 15->0.
  - The first free cell goes to DONE.
  - A hit on (15,15) goes to DONE with no_space.
- DONE: one cycle.
  - Pulse food_valid, or pulse no_space with food_x/y unchanged.
  - waitrequest=0; go to IDLE.
  - start is not accepted in DONE.
- start while busy: ignored.
- query_hit is ignored except in RAND_W/SCAN_W.
- Reset values:
  - waitrequest=0, query_valid=0, query_x/y=0
  - food_valid=0, no_space=0, food_x/y=0
  - state IDLE, LFSR=LFSR_SEED

## Timing
- Acceptance is at edge T: IDLE with start=1.
- waitrequest=1 from T+1 through the last W state. It is 0 in DONE.
- Query/response:
  - query_valid is high in the cycle after the request or the previous sample.
  - Responder contract: query_hit is registered and valid exactly one cycle after query_valid.
  - query_x/y hold stable while query_valid=1.
- Random try k (0-based):
  - query at T+1+2k, sampled at T+2+2k.
  - Success gives food_valid at T+3+2k.
  - Best-case latency is 3 cycles.
- Scan cell n (n = y*16+x):
  - query at T+33+2n (MAX_TRIES=16).
  - Success gives food_valid at T+35+2n.
- Full board: no_space at T+545.
- Reset asserted mid-operation: the next edge returns every output to its reset value. No partial result is emitted.

## Structure
- Shared package snake_pkg:
  - GRID_BITS/GRID_SIZE constants
  - coord_t typedef (logic [3:0])
  - the food colour constant, shared with game_path/game_plot
- Sub-module lfsr8 (clk, rst_n, seed parameter, 8-bit out).
  - Kept separate so game_path can reuse it.
- The FSM, try counter, and scan counter live in food_gen.

## Test plan
- Reset -> waitrequest=0, query_valid=0, food_x/y=0, food_valid=0, no_space=0; LFSR output = 8'hA5.
- Empty board (responder hit=0), start at T -> query_valid at T+1 with the LFSR candidate; food_valid at T+3, food_x/y equal to that candidate; waitrequest 1 at T+1..T+2, 0 at T+3.
- Responder reports hit for the first 3 candidates -> queries at T+1, T+3, T+5, T+7; food_valid at T+9 with the 4th candidate.
- Responder marks every cell occupied except (5,2) -> 16 random queries (all hit unless a candidate is (5,2)), then scan queries from (0,0) at T+33; food_valid at T+109 with food=(5,2).
- All 256 cells occupied -> no_space pulse at T+545; food_valid stays 0; food_x/y keep the previous values.
- rst_n low for one cycle during a scan -> next cycle query_valid=0, waitrequest=0; a new start gives a candidate from an LFSR restarted at 8'hA5.
